// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, data width and sequencer state encoding
package alu_pkg;
  localparam int DATA_W = 16;
  localparam logic ALU_OP_PASS = 1'b0;
  localparam logic ALU_OP_ADD = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
endpackage

// File: rtl/alu.sv
// alu: two-operation ALU, op 0 passes in_data1, op 1 adds both operands modulo 2^DATA_W
module alu
  import alu_pkg::*;
(
  input  logic              op,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic [DATA_W-1:0] out
);
  assign out = (op == ALU_OP_ADD) ? in_data1 + in_data2 : in_data1;
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multiplies by repeated ALU addition with a start/busy/done handshake
// ALU_MUL_SEQ_ABORT_EN adds an abort input that returns LOAD/ADD to IDLE without a done pulse
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [CNT_W-1:0]  count,
`ifdef ALU_MUL_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);
  state_t state, nxt;
  logic [DATA_W-1:0] acc, mcand, in_data1, alu_out;
  logic [CNT_W-1:0] cnt;
  logic alu_op, stop;
`ifdef ALU_MUL_SEQ_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif
  alu u_alu (
    .op      (alu_op),
    .in_data1(in_data1),
    .in_data2(mcand),
    .out     (alu_out)
  );
  // LOAD clears the accumulator through the ALU by passing a zero operand
  always_comb begin
    alu_op = (state == ADD) ? ALU_OP_ADD : ALU_OP_PASS;
    in_data1 = (state == LOAD) ? '0 : acc;
    nxt = (state == IDLE) ? (start ? LOAD : IDLE) :
          (state == DONE) ? IDLE :
          stop ? IDLE :
          (state == LOAD) ? ((cnt == '0) ? DONE : ADD) :
          ((cnt == CNT_W'(1)) ? DONE : ADD);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mcand <= multiplicand;
        cnt <= count;
      end
      if (state == LOAD) begin
        acc <= alu_out;
        ovf <= 1'b0;
      end
      if (state == ADD) begin
        acc <= alu_out;
        cnt <= cnt - CNT_W'(1);
        ovf <= ovf | (alu_out < acc);
      end
    end
  end
  assign busy = (state == LOAD) || (state == ADD);
  assign done = (state == DONE);
  assign result = acc;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized self-checking bench against an arithmetic product model
module tb_alu_mul_seq;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] multiplicand = 0;
  logic [7:0] count = 0;
  logic busy, done, ovf;
  logic [15:0] result;
`ifdef ALU_MUL_SEQ_ABORT_EN
  logic abort = 0;
`endif
  int n_tests = 0, n_fail = 0;
  logic [15:0] prev = 0;

  alu_mul_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand), .count(count),
`ifdef ALU_MUL_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] m, input logic [7:0] c, input bit spam);
    int n, prod;
    prod = int'(m) * int'(c);
    @(negedge clk);
    multiplicand = m; count = c; start = 1;
    @(posedge clk); #1;
    if (!spam) start = 0;
    multiplicand = 16'($urandom); count = 8'($urandom);
    check("hold_prev", result, prev);
    n = 0;
    while (!done && n < 400) begin
      check("busy_run", busy, 1);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, int'(c) + 1);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("result", result, prod[15:0]);
    check("ovf", ovf, prod > 65535);
    @(posedge clk); #1;
    start = 0;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("result_keep", result, prod[15:0]);
    prev = prod[15:0];
  endtask

  initial begin
    bit seen;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk) rst = 0;
    run_op(16'd7, 8'd3, 0);
    run_op(16'h1234, 8'd0, 0);
    run_op(16'h8000, 8'd3, 0);
    run_op(16'd5, 8'd2, 0);
    run_op(16'd10, 8'd4, 1);
    run_op(16'd1, 8'd255, 0);
    run_op(16'hffff, 8'd255, 0);
    for (int i = 0; i < 10; i++)
      run_op(16'($urandom), 8'($urandom_range(0, 20)), 1'($urandom));
    @(negedge clk);
    multiplicand = 16'd9; count = 8'd200; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    check("post_rst_quiet", seen, 0);
    prev = 0;
    run_op(16'd2, 8'd2, 0);
`ifdef ALU_MUL_SEQ_ABORT_EN
    @(negedge clk);
    multiplicand = 16'd5; count = 8'd10; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 15);
    check("abort_ovf", ovf, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    check("abort_quiet", seen, 0);
    prev = 16'd15;
    run_op(16'd3, 8'd3, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle controller that sequences the 16-bit two-operation ALU (op 0 = pass in_data1, op 1 = in_data1 + in_data2) to compute multiplicand × count by repeated addition.
- Holds the accumulator, multiplicand and iteration counter registers.
- Drives alu_op and the ALU operand muxes every cycle.
- Sits between the lab control panel/test harness and the ALU datapath; uses a start/busy/done handshake.

Parameters:
- CNT_W, 8, width of the repeat-count operand and the internal down-counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE
- multiplicand  input  16  addend; captured on the accepted start
- count  input  CNT_W  number of additions; captured on the accepted start
- busy  output  1  high in LOAD and ADD
- done  output  1  one-cycle pulse when the result becomes valid
- result  output  16  accumulator value; held stable outside ADD
- ovf  output  1  sticky carry-out flag for the current operation
- abort  input  1  present only with ALU_MUL_SEQ_ABORT_EN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc=0, mcand=0, cnt=0.
  - busy=0, done=0, result=0, ovf=0.
- States: IDLE, LOAD, ADD, DONE.
- IDLE:
  - start=1 captures multiplicand→mcand and count→cnt, then goes to LOAD.
  - start=0 stays in IDLE.
- LOAD (1 cycle):
  - alu_op=0, in_data1=16'h0000.
  - acc←ALU output (0), ovf←0.
  - cnt==0 → DONE; otherwise → ADD.
- ADD:
  - alu_op=1, in_data1=acc, in_data2=mcand.
  - acc←ALU output, cnt←cnt−1.
  - Carry detection: ovf←ovf | (sum < acc). Addition wraps modulo 2^16.
  - Leaves ADD for DONE on the cycle in which cnt==1 (the last addition).
- DONE (1 cycle): done=1, then → IDLE.
- Outputs:
  - busy is combinational from state: 1 in LOAD and ADD only.
  - result=acc, registered.
- Latency: start accepted at edge T → done high in cycle T+count+2. count=0 gives done at T+2 with result=0.
- start while busy or in DONE: ignored. No queueing.
- start in the same cycle that done is high: ignored. The next accepted start is the first cycle back in IDLE.
- Back-to-back operation: a new start resets ovf and acc in LOAD. result keeps its previous value until LOAD.
- count at maximum (2^CNT_W−1): must complete without counter wrap; cnt never decrements below 0.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- alu_op and operand muxes are driven as defined in every state. In IDLE/DONE, alu_op=0 and in_data1=acc, so no x reaches the ALU.

Optional Feature:
- Macro: ALU_MUL_SEQ_ABORT_EN.
- Defined:
  - Adds the 1-bit input port abort.
  - abort=1 in LOAD or ADD → IDLE next cycle; no done pulse.
  - acc/result keep the partial value; ovf keeps its value.
  - abort in IDLE/DONE has no effect.
  - abort takes priority over the LOAD→DONE and ADD→DONE transitions.
- Not defined: no abort port; an operation always runs to completion.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_OP_PASS=1'b0 and ALU_OP_ADD=1'b1.
  - DATA_W=16.
  - State typedef/localparams for IDLE/LOAD/ADD/DONE.
- One sub-module: the existing alu, instantiated once. All control and registers stay in alu_mul_seq.

Test Plan:
- Reset then start with multiplicand=16'd7, count=3 → busy for 4 cycles, done at T+5, result=16'd21, ovf=0.
- count=0, multiplicand=16'h1234 → done at T+2, result=16'h0000, ovf=0.
- multiplicand=16'h8000, count=3 → result=16'h8000, ovf=1. A second run with 5×2 → result=10, ovf=0.
- start pulsed every cycle during a 10×4 run → exactly one done, result=40. The start coincident with done is ignored.
- rst asserted mid-ADD of 9×200 → outputs 0 immediately, no done. A following 2×2 run → result=4.
- ALU_MUL_SEQ_ABORT_EN: abort in the third ADD cycle of 5×10 → IDLE, no done, result=15.
